// File: rtl/sign_narrow_pkg.sv
// Shared types and constants for the sign_narrow block: FSM state encoding,
// saturation limits and the signed-16 range test used by narrow_core.
package sign_narrow_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOne,
    StLo,
    StHi
  } state_e;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // A 32-bit word survives narrowing iff its upper half is a pure sign extension.
  function automatic logic fits_s16(input logic [31:0] word);
    return word[31:16] == {16{word[15]}};
  endfunction

endpackage

// File: rtl/narrow_core.sv
// Combinational signed 32->16 narrowing: range check plus saturation or truncation.
// Saturation on out-of-range words is enabled by defining SIGN_NARROW_SATURATE_EN.
module narrow_core
  import sign_narrow_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [15:0] data_o,
  output logic        fits_o
);

  always_comb begin
    fits_o = fits_s16(word_i);
`ifdef SIGN_NARROW_SATURATE_EN
    if (fits_o) begin
      data_o = word_i[15:0];
    end else begin
      data_o = word_i[31] ? SAT_NEG : SAT_POS;
    end
`else
    data_o = word_i[15:0];
`endif
  end

endmodule

// File: rtl/sign_narrow.sv
// Narrows a 32-bit word to one signed-16 beat, or splits it into two 16-bit beats,
// with a saturating overflow counter. Saturation mode: define SIGN_NARROW_SATURATE_EN.
module sign_narrow
  import sign_narrow_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_split,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_ovf_q, out_ovf_d;
  logic [15:0]      hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] core_data;
  logic        core_fits;
  logic        in_hs;
  logic        out_hs;

  narrow_core u_narrow_core (
    .word_i (in_data),
    .data_o (core_data),
    .fits_o (core_fits)
  );

  // Gated by rst so no word is ever taken while the block is being cleared.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:      in_ready = ~rst;
      StOne, StHi: in_ready = ~rst & out_ready;
      StLo:        in_ready = 1'b0;
      default:     in_ready = 1'b0;
    endcase
  end

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    hi_d        = hi_q;

    unique case (state_q)
      StIdle: begin
      end
      StOne, StHi: begin
        if (out_hs) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      StLo: begin
        if (out_hs) begin
          state_d    = StHi;
          out_data_d = hi_q;
          out_last_d = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase

    // A new word overrides the drain step so ONE/HI can reload without a bubble.
    if (in_hs) begin
      out_valid_d = 1'b1;
      if (in_split) begin
        state_d    = StLo;
        out_data_d = in_data[15:0];
        out_last_d = 1'b0;
        out_ovf_d  = 1'b0;
        hi_d       = in_data[31:16];
      end else begin
        state_d    = StOne;
        out_data_d = core_data;
        out_last_d = 1'b1;
        out_ovf_d  = ~core_fits;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = '0;
    end else if (in_hs && !in_split && !core_fits && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      hi_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_sign_narrow.sv
// Scoreboard bench for sign_narrow: accepted words are expanded into expected beats by
// an arithmetic reference model; a monitor pops and compares every delivered beat.
module tb_sign_narrow;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_split;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_last;
  logic             out_ovf;
  logic [CNT_W-1:0] ovf_count;
  logic             ovf_clr;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic        o;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    passed = 0;
  int    cnt_m  = 0;
  bit    rand_ready = 1'b0;
  int    last_wait;

  sign_narrow #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_split  (in_split),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
  endtask

  function automatic bit fits_ref(input logic [31:0] w);
    return ($signed(w) >= -32768) && ($signed(w) <= 32767);
  endfunction

  function automatic logic [15:0] narrow_ref(input logic [31:0] w);
    if (fits_ref(w)) return w[15:0];
`ifdef SIGN_NARROW_SATURATE_EN
    return ($signed(w) < 0) ? 16'h8000 : 16'h7FFF;
`else
    return w[15:0];
`endif
  endfunction

  // Input-side monitor: expands each accepted word and tracks the expected counter.
  always @(negedge clk) begin
    if (rst) begin
      cnt_m = 0;
    end else begin
      chk("ovf_count", 32'(ovf_count), 32'(cnt_m));
      if (in_valid && in_ready) begin
        if (in_split) begin
          exp_q.push_back('{d: in_data[15:0], l: 1'b0, o: 1'b0});
          exp_q.push_back('{d: in_data[31:16], l: 1'b1, o: 1'b0});
        end else begin
          exp_q.push_back('{d: narrow_ref(in_data), l: 1'b1, o: !fits_ref(in_data)});
        end
      end
      if (ovf_clr) cnt_m = 0;
      else if (in_valid && in_ready && !in_split && !fits_ref(in_data) && cnt_m < CNT_MAX)
        cnt_m++;
    end
  end

  // Output-side monitor: stall stability and in-order beat comparison.
  beat_t held;
  bit    stall_v = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      exp_q.delete();
      stall_v = 1'b0;
    end else if (out_valid) begin
      if (stall_v) chk("stall_stable", {15'd0, out_data, out_last, out_ovf}, {15'd0, held});
      if (out_ready) begin
        stall_v = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {16'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.d));
          chk("beat_last", 32'(out_last), 32'(e.l));
          chk("beat_ovf", 32'(out_ovf), 32'(e.o));
        end
      end else begin
        stall_v = 1'b1;
        held    = '{d: out_data, l: out_last, o: out_ovf};
      end
    end else begin
      stall_v = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] w, input logic s);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    in_split = s;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid  = 1'b0;
    last_wait = n;
    if (!acc) chk("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] edges[6];
    logic [31:0] r;
    edges[0] = 32'h0000_7FFF;
    edges[1] = 32'hFFFF_8000;
    edges[2] = 32'h0000_8000;
    edges[3] = 32'hFFFF_7FFF;
    edges[4] = 32'h8000_0000;
    edges[5] = 32'h7FFF_FFFF;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return {{16{r[15]}}, r[15:0]};
      1:       return r;
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_split  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_last_ovf", {30'd0, out_last, out_ovf}, 32'd0);
    @(posedge clk);
    #1;

    // Narrow boundary words.
    out_ready = 1'b1;
    send(32'hFFFF_8000, 1'b0);
    send(32'h0001_2345, 1'b0);
    send(32'h8000_0000, 1'b0);
    drain();
    chk("count_after_narrow", 32'(ovf_count), 32'd2);

    // Split with a three-cycle stall on the low half.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lo_valid", 32'(out_valid), 32'd1);
      chk("lo_in_ready", 32'(in_ready), 32'd0);
      chk("lo_data", 32'(out_data), 32'h0000_BEEF);
      chk("lo_last", 32'(out_last), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hi_data", 32'(out_data), 32'h0000_DEAD);
    chk("hi_last", 32'(out_last), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back narrow words must each be taken on their first cycle.
    for (int i = 0; i < 8; i++) begin
      w = rand_word();
      send(w, 1'b0);
      chk("b2b_accept_cycles", 32'(last_wait), 32'd1);
    end
    drain();

    // Reset while the high half is pending.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_hi_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hi_in_ready", 32'(in_ready), 32'd1);
    chk("rst_hi_count", 32'(ovf_count), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_hi_no_beat", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Counter saturation, then clear against a coincident overflow.
    for (int i = 0; i < 260; i++) begin
      w = $urandom;
      while (fits_ref(w)) w = $urandom;
      send(w, 1'b0);
    end
    drain();
    chk("count_saturated", 32'(ovf_count), 32'(CNT_MAX));
    ovf_clr = 1'b1;
    send(32'h0001_0000, 1'b0);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("count_clr_wins", 32'(ovf_count), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Randomised mix with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ovf_clr = ($urandom_range(0, 15) == 0);
      send(rand_word(), 1'($urandom_range(0, 1)));
      ovf_clr = 1'b0;
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of overflow event counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  input word present.
REQ-005 SHALL have port in_ready  out  1  block accepts input this cycle.
REQ-006 SHALL have port in_data  in  32  register value to narrow/split.
REQ-007 SHALL have port in_split  in  1  0 = narrow to one 16-bit beat, 1 = emit two 16-bit beats.
REQ-008 SHALL have port out_valid  out  1  output beat present.
REQ-009 SHALL have port out_ready  in  1  consumer accepts beat.
REQ-010 SHALL have port out_data  out  16  beat payload.
REQ-011 SHALL have port out_last  out  1  final beat of current word.
REQ-012 SHALL have port out_ovf  out  1  narrow beat was out of signed-16 range.
REQ-013 SHALL have port ovf_count  out  CNT_W  saturating count of overflowing narrow words.
REQ-014 SHALL have port ovf_clr  in  1  synchronous clear of ovf_count.

Function
REQ-015 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-016 FSM states IDLE, ONE (narrow beat held), LO (low half held), HI (high half held).
REQ-017 in_ready SHALL be 1 in IDLE, and in ONE/HI only when out_ready=1; 0 in LO.
REQ-018 On input handshake: in_split=0 -> ONE; in_split=1 -> LO; out_valid asserts next cycle (latency 1, all outputs registered).
REQ-019 LO: out_data=in_data[15:0], out_last=0; on output handshake -> HI with out_data=in_data[31:16], out_last=1.
REQ-020 ONE/HI: on output handshake with new input handshake same cycle -> load new word (no bubble); otherwise -> IDLE, out_valid=0.
REQ-021 Range check: word fits iff in_data[31:16] == {16{in_data[15]}}.
REQ-022 Narrow fitting word: out_data=in_data[15:0], out_ovf=0, out_last=1.
REQ-023 Narrow non-fitting word: out_ovf=1; payload per REQ-030/031.
REQ-024 Split beats SHALL always have out_ovf=0 and never count.
REQ-025 ovf_count increments by 1 on input handshake of non-fitting narrow word; holds at all-ones (no wrap).
REQ-026 ovf_clr=1 SHALL zero ovf_count next cycle and wins over a coincident increment.
REQ-027 out_data/out_last/out_ovf SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst=1 SHALL force state IDLE, out_valid=0, out_data=0, out_last=0, out_ovf=0, ovf_count=0; in_ready=1 the cycle after rst deasserts.
REQ-029 rst in any state (incl. LO/HI mid-word) SHALL discard the pending word; no stale beat after reset.

Configuration
REQ-030 With SIGN_NARROW_SATURATE_EN defined: non-fitting narrow word yields 16'h7FFF if in_data[31]=0, 16'h8000 if in_data[31]=1.
REQ-031 Without SIGN_NARROW_SATURATE_EN: non-fitting narrow word yields in_data[15:0] (truncate); out_ovf and counting unchanged.

Structure
REQ-032 Package sign_narrow_pkg SHALL hold state enum (IDLE/ONE/LO/HI) and constants SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
REQ-033 Combinational range check + saturation/truncation SHALL live in sub-module narrow_core (32-bit in -> 16-bit data + fits flag); FSM, registers, counter in sign_narrow.

Verification
REQ-034 Narrow 32'hFFFF8000, out_ready=1 -> one beat 16'h8000, last=1, ovf=0, count 0.
REQ-035 Narrow 32'h00012345 -> ovf=1, data 16'h7FFF (macro on) / 16'h2345 (off), count 1; narrow 32'h80000000 -> 16'h8000 (on) / 16'h0000 (off).
REQ-036 Split 32'hDEADBEEF, out_ready low 3 cycles -> 16'hBEEF last=0 held stable, then 16'hDEAD last=1; in_ready=0 during LO.
REQ-037 Back-to-back narrow words, out_ready=1 -> one beat per cycle, in_ready continuously 1, order preserved.
REQ-038 rst pulsed while in HI -> next cycle out_valid=0, in_ready=1, count 0; no 16'hDEAD beat emitted.
REQ-039 260 overflowing narrow words (CNT_W=8) -> ovf_count=255; ovf_clr coincident with overflow -> 0.
